// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared mode encoding for the JK universal register
//
// Purpose: mode type and mode-select constants shared by the register top
//          and its testbench.
// Contents:
//   mode_t           3-bit operation select
//   MODE_HOLD..CPL   mode encodings
package jk_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_JK   = 3'b001;
  localparam mode_t MODE_LOAD = 3'b010;
  localparam mode_t MODE_SHL  = 3'b011;
  localparam mode_t MODE_SHR  = 3'b100;
  localparam mode_t MODE_UP   = 3'b101;
  localparam mode_t MODE_DOWN = 3'b110;
  localparam mode_t MODE_CPL  = 3'b111;

endpackage

// File: rtl/jk_next_state.sv
// rtl/jk_next_state.sv - per-bit JK flip-flop next-state logic
//
// Purpose: combinational characteristic equation Q+ = J&~Q | ~K&Q applied
//          independently to every bit (00 hold, 01 clear, 10 set, 11 toggle).
// Ports:
//   i_q       current state
//   i_j       per-bit J
//   i_k       per-bit K
//   o_q_next  per-bit next state
module jk_next_state #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_j,
  input  logic [WIDTH-1:0] i_k,
  output logic [WIDTH-1:0] o_q_next
);

  assign o_q_next = (i_j & ~i_q) | (~i_k & i_q);

endmodule

// File: rtl/jk_universal_register.sv
// rtl/jk_universal_register.sv - WIDTH-bit universal register with JK per-bit mode
//
// Purpose: hold / JK / load / shift left / shift right / count up / count
//          down / complement register with async clear and sync preset.
// Ports:
//   clock_pos       rising-edge clock
//   reset_neg       async active-low reset to RESET_VALUE
//   preset_neg      sync active-low preset to PRESET_VALUE
//   enable          clock enable; low holds Q
//   mode            operation select (jk_pkg::MODE_*)
//   signal_J/K      per-bit J and K, used in JK mode
//   data_in         parallel load data
//   serial_in       shift input bit
//   signal_out      Q
//   signal_out_neg  ~Q
//   serial_out      bit leaving the register in the current shift direction
//   terminal_count  count about to wrap on the next edge
//   wrap_pulse      one cycle high after a wrapping edge
module jk_universal_register
  import jk_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clock_pos,
  input  logic             reset_neg,
  input  logic             preset_neg,
  input  logic             enable,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] signal_J,
  input  logic [WIDTH-1:0] signal_K,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] signal_out,
  output logic [WIDTH-1:0] signal_out_neg,
  output logic             serial_out,
  output logic             terminal_count,
  output logic             wrap_pulse
);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_jk_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_terminal_count;

  jk_next_state #(.WIDTH(WIDTH)) u_jk_next_state (
    .i_q      (r_q),
    .i_j      (signal_J),
    .i_k      (signal_K),
    .o_q_next (w_jk_next)
  );

  always_comb begin
    w_q_next = r_q;
    unique case (mode)
      MODE_HOLD: w_q_next = r_q;
      MODE_JK:   w_q_next = w_jk_next;
      MODE_LOAD: w_q_next = data_in;
      MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], serial_in};
      MODE_SHR:  w_q_next = {serial_in, r_q[WIDTH-1:1]};
      MODE_UP:   w_q_next = r_q + 1'b1;
      MODE_DOWN: w_q_next = r_q - 1'b1;
      MODE_CPL:  w_q_next = ~r_q;
      default:   w_q_next = r_q;
    endcase
  end

  // Flags the edge on which the count will wrap, so wrap_pulse can follow it.
  assign w_terminal_count = enable &
                            (((mode == MODE_UP)   && (r_q == {WIDTH{1'b1}})) ||
                             ((mode == MODE_DOWN) && (r_q == {WIDTH{1'b0}})));

  always_ff @(posedge clock_pos or negedge reset_neg) begin
    if (!reset_neg) begin
      r_q    <= RESET_VALUE;
      r_wrap <= 1'b0;
    end else if (!preset_neg) begin
      r_q    <= PRESET_VALUE;
      r_wrap <= 1'b0;
    end else if (!enable) begin
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_terminal_count;
    end
  end

  assign signal_out     = r_q;
  assign signal_out_neg = ~r_q;
  // Right shifts drain the LSB; every other mode presents the MSB.
  assign serial_out     = (mode == MODE_SHR) ? r_q[0] : r_q[WIDTH-1];
  assign terminal_count = w_terminal_count;
  assign wrap_pulse     = r_wrap;

endmodule

// File: tb/tb_jk_universal_register.sv
// tb/tb_jk_universal_register.sv - directed self-checking bench for jk_universal_register
module tb_jk_universal_register;
  import jk_pkg::*;

  localparam int WIDTH = 8;

  logic             clock_pos = 1'b0;
  logic             reset_neg;
  logic             preset_neg;
  logic             enable;
  mode_t            mode;
  logic [WIDTH-1:0] signal_J;
  logic [WIDTH-1:0] signal_K;
  logic [WIDTH-1:0] data_in;
  logic             serial_in;
  logic [WIDTH-1:0] signal_out;
  logic [WIDTH-1:0] signal_out_neg;
  logic             serial_out;
  logic             terminal_count;
  logic             wrap_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  jk_universal_register #(.WIDTH(WIDTH)) dut (
    .clock_pos      (clock_pos),
    .reset_neg      (reset_neg),
    .preset_neg     (preset_neg),
    .enable         (enable),
    .mode           (mode),
    .signal_J       (signal_J),
    .signal_K       (signal_K),
    .data_in        (data_in),
    .serial_in      (serial_in),
    .signal_out     (signal_out),
    .signal_out_neg (signal_out_neg),
    .serial_out     (serial_out),
    .terminal_count (terminal_count),
    .wrap_pulse     (wrap_pulse)
  );

  always #5 clock_pos = ~clock_pos;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_pos);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    enable  = 1'b1;
    mode    = MODE_LOAD;
    data_in = v;
    step();
  endtask

  initial begin
    reset_neg  = 1'b0;
    preset_neg = 1'b1;
    enable     = 1'b0;
    mode       = MODE_HOLD;
    signal_J   = '0;
    signal_K   = '0;
    data_in    = '0;
    serial_in  = 1'b0;

    // Reset state
    step();
    step();
    check("rst_q", signal_out, 8'h00);
    check("rst_qn", signal_out_neg, 8'hFF);
    check("rst_wrap", wrap_pulse, 1'b0);
    reset_neg = 1'b1;

    // Async reset mid-cycle from A5
    load(8'hA5);
    check("load_a5", signal_out, 8'hA5);
    mode = MODE_UP;
    #2;
    reset_neg = 1'b0;
    #1;
    check("async_rst_q", signal_out, 8'h00);
    check("async_rst_wrap", wrap_pulse, 1'b0);
    #2;
    reset_neg = 1'b1;
    step();
    check("post_rst_up", signal_out, 8'h01);

    // Preset overrides enable low
    preset_neg = 1'b0;
    enable     = 1'b0;
    mode       = MODE_UP;
    step();
    check("preset_q", signal_out, 8'hFF);
    check("preset_wrap", wrap_pulse, 1'b0);
    preset_neg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("en_low_hold", signal_out, 8'hFF);
    end
    check("en_low_tc", terminal_count, 1'b0);

    // JK mode
    load(8'b1100_1010);
    mode     = MODE_JK;
    signal_J = 8'b1010_0000;
    signal_K = 8'b0110_0001;
    step();
    check("jk_q", signal_out, 8'b1010_1010);

    // Up-count wrap
    load(8'hFE);
    mode = MODE_UP;
    #1;
    check("up_tc_fe", terminal_count, 1'b0);
    step();
    check("up_q_ff", signal_out, 8'hFF);
    check("up_tc_ff", terminal_count, 1'b1);
    check("up_wrap_ff", wrap_pulse, 1'b0);
    step();
    check("up_q_00", signal_out, 8'h00);
    check("up_tc_00", terminal_count, 1'b0);
    check("up_wrap_00", wrap_pulse, 1'b1);
    step();
    check("up_q_01", signal_out, 8'h01);
    check("up_wrap_01", wrap_pulse, 1'b0);

    // Down-count wrap
    load(8'h01);
    mode = MODE_DOWN;
    #1;
    check("dn_tc_01", terminal_count, 1'b0);
    step();
    check("dn_q_00", signal_out, 8'h00);
    check("dn_tc_00", terminal_count, 1'b1);
    check("dn_wrap_00", wrap_pulse, 1'b0);
    step();
    check("dn_q_ff", signal_out, 8'hFF);
    check("dn_wrap_ff", wrap_pulse, 1'b1);
    check("dn_tc_ff", terminal_count, 1'b0);
    enable = 1'b0;
    step();
    check("dn_en_low_wrap", wrap_pulse, 1'b0);
    check("dn_en_low_q", signal_out, 8'hFF);

    // Shift left then right
    load(8'h81);
    mode      = MODE_SHL;
    serial_in = 1'b0;
    #1;
    check("shl_sout_pre", serial_out, 1'b1);
    step();
    check("shl_q", signal_out, 8'h02);
    check("shl_sout_post", serial_out, 1'b0);
    mode      = MODE_SHR;
    serial_in = 1'b1;
    #1;
    check("shr_sout_pre", serial_out, 1'b0);
    step();
    check("shr_q", signal_out, 8'h81);
    check("shr_sout_post", serial_out, 1'b1);

    // Complement and hold
    mode = MODE_CPL;
    step();
    check("cpl_q", signal_out, 8'h7E);
    check("cpl_qn", signal_out_neg, 8'h81);
    mode = MODE_HOLD;
    step();
    check("hold_q", signal_out, 8'h7E);

    // Enable low blocks a load
    enable  = 1'b0;
    mode    = MODE_LOAD;
    data_in = 8'h33;
    step();
    check("en_low_load", signal_out, 8'h7E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
